// File: rtl/io_wait_controller.sv
// IN/OUT instruction sequencer: halts the PC for IN until a debounced
// press-and-release, then strobes the register write; OUT loads a display latch.
module io_wait_controller #(
    parameter int          DATA_W          = 32,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [5:0]  OP_IN           = 6'b100000,
    parameter logic [5:0]  OP_OUT          = 6'b100010
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic              botao,
    input  logic [DATA_W-1:0] switches,
    input  logic [DATA_W-1:0] out_data,
    output logic              halt,
    output logic [DATA_W-1:0] in_data,
    output logic              in_write,
    output logic [DATA_W-1:0] out_display,
    output logic              out_valid,
    output logic [1:0]        busy_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        WAIT_RELEASE = 2'b10,
        COMMIT       = 2'b11
    } state_t;

    state_t           state, state_d;
    logic             sync_q1, sync_q2;
    logic             deb;
    logic [CNT_W-1:0] cnt;
    logic             deb_flip;
    logic             halt_c;
    logic             capture;
    logic             out_load;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= botao;
            sync_q2 <= sync_q1;
        end
    end

    // Level change accepted only after DEBOUNCE_CYCLES consecutive differing samples
    assign deb_flip = (sync_q2 != deb) && (cnt == CNT_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync_q2 == deb) begin
            cnt <= '0;
        end else if (deb_flip) begin
            deb <= ~deb;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        halt_c   = 1'b0;
        in_write = 1'b0;
        capture  = 1'b0;
        out_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (opcode == OP_IN) begin
                    halt_c  = 1'b1;
                    state_d = WAIT_PRESS;
                end else if (opcode == OP_OUT) begin
                    out_load = 1'b1;
                end
            end
            WAIT_PRESS: begin
                halt_c = 1'b1;
                if (deb && !deb_flip) begin
                    capture = 1'b1;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                halt_c = 1'b1;
                if (!deb) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                in_write = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign halt       = halt_c & ~reset;
    assign busy_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_data     <= '0;
            out_display <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (capture) begin
                in_data <= switches;
            end
            if (out_load) begin
                out_display <= out_data;
                out_valid   <= 1'b1;
            end
        end
    end

endmodule
